// File: rtl/fft_peak_pkg.sv
// Shared state encoding, widths and reset constants for the FFT peak sequencer.
package fft_peak_pkg;

    localparam int ADDR_W = 8;
    localparam int MAG_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_FFT,
        ST_SCAN,
        ST_DRAIN,
        ST_HOLD
    } state_t;

    localparam state_t             RST_STATE = ST_IDLE;
    localparam logic [ADDR_W-1:0]  RST_BIN   = '0;
    localparam logic [MAG_W-1:0]   RST_MAG   = '0;

endpackage

// File: rtl/fft_peak_ctrl_if.sv
// Signal bundle between the peak sequencer, the fft_sm core and the pitch/display consumer.
interface fft_peak_ctrl_if;
    import fft_peak_pkg::*;

    logic              Go;
    logic              FftStart;
    logic              FftDone;
    logic              FftReady;
    logic [ADDR_W-1:0] Inspect;
    logic [MAG_W-1:0]  Result;
    logic [ADDR_W-1:0] PeakBin;
    logic [MAG_W-1:0]  PeakMag;
    logic              PeakValid;
    logic              Ack;
    logic              Busy;
    logic              Err;

    modport master (
        input  Go, FftDone, FftReady, Result, Ack,
        output FftStart, Inspect, PeakBin, PeakMag, PeakValid, Busy, Err
    );

    modport slave (
        output Go, FftDone, FftReady, Result, Ack,
        input  FftStart, Inspect, PeakBin, PeakMag, PeakValid, Busy, Err
    );

endinterface

// File: rtl/fft_peak_tracker.sv
// Peak tracker: delays each scan address by the read latency, keeps the running maximum,
// and restores the last committed peak when a measurement is abandoned.
module fft_peak_tracker
    import fft_peak_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_first,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [MAG_W-1:0]  result,
    input  logic              flush,
    input  logic              commit,
    output logic [ADDR_W-1:0] peak_bin,
    output logic [MAG_W-1:0]  peak_mag
);

    logic              cur_valid;
    logic              cur_first;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] shadow_bin;
    logic [MAG_W-1:0]  shadow_mag;

    generate
        if (READ_LAT == 0) begin : g_direct
            assign cur_valid = req_valid;
            assign cur_first = req_first;
            assign cur_addr  = req_addr;
        end else begin : g_tags
            logic [READ_LAT-1:0] vld_pipe;
            logic [READ_LAT-1:0] first_pipe;
            logic [ADDR_W-1:0]   addr_pipe [READ_LAT];

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    vld_pipe   <= '0;
                    first_pipe <= '0;
                end else begin
                    vld_pipe[0]   <= req_valid;
                    first_pipe[0] <= req_first;
                    for (int i = 1; i < READ_LAT; i++) begin
                        vld_pipe[i]   <= vld_pipe[i-1];
                        first_pipe[i] <= first_pipe[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                addr_pipe[0] <= req_addr;
                for (int i = 1; i < READ_LAT; i++) begin
                    addr_pipe[i] <= addr_pipe[i-1];
                end
            end

            assign cur_valid = vld_pipe[READ_LAT-1];
            assign cur_first = first_pipe[READ_LAT-1];
            assign cur_addr  = addr_pipe[READ_LAT-1];
        end
    endgenerate

    // Strict compare keeps the lowest bin on ties; an abort wins over any in-flight update.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_bin   <= RST_BIN;
            peak_mag   <= RST_MAG;
            shadow_bin <= RST_BIN;
            shadow_mag <= RST_MAG;
        end else if (flush) begin
            peak_bin <= shadow_bin;
            peak_mag <= shadow_mag;
        end else begin
            if (cur_valid && (cur_first || (result > peak_mag))) begin
                peak_bin <= cur_addr;
                peak_mag <= result;
            end
            if (commit) begin
                shadow_bin <= peak_bin;
                shadow_mag <= peak_mag;
            end
        end
    end

endmodule

// File: rtl/fft_peak_ctrl.sv
// Sequencer over fft_sm: start one FFT, sweep the bins, report the peak via Valid/Ack.
// Define FFT_PEAK_AUTORUN_EN for free-running measurements with a one-cycle PeakValid pulse.
module fft_peak_ctrl
    import fft_peak_pkg::*;
#(
    parameter int NBINS    = 128,
    parameter int SKIP_DC  = 1,
    parameter int READ_LAT = 1,
    parameter int TIMEOUT  = 4096
) (
    input  logic           Clk,
    input  logic           Reset,
    fft_peak_ctrl_if.master bus
);

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr, addr_next;
    logic [31:0]       tcnt, tcnt_next;
    logic [1:0]        dcnt, dcnt_next;
    logic              err_q, err_next;
    logic              abort;
    logic [ADDR_W-1:0] peak_bin;
    logic [MAG_W-1:0]  peak_mag;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= RST_STATE;
            addr  <= '0;
            tcnt  <= '0;
            dcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            addr  <= addr_next;
            tcnt  <= tcnt_next;
            dcnt  <= dcnt_next;
            err_q <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        addr_next  = addr;
        tcnt_next  = tcnt;
        dcnt_next  = dcnt;
        err_next   = 1'b0;
        abort      = 1'b0;
        case (state)
            ST_IDLE: begin
`ifdef FFT_PEAK_AUTORUN_EN
                state_next = ST_START;
`else
                if (bus.Go) state_next = ST_START;
`endif
            end
            ST_START: begin
                tcnt_next  = '0;
                state_next = ST_WAIT_FFT;
            end
            ST_WAIT_FFT: begin
                if (bus.FftDone && bus.FftReady) begin
                    addr_next  = ADDR_W'(SKIP_DC);
                    state_next = ST_SCAN;
                end else if (tcnt == 32'(TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    tcnt_next = tcnt + 32'd1;
                end
            end
            ST_SCAN: begin
                if (!bus.FftReady) begin
                    abort      = 1'b1;
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end else if (addr == ADDR_W'(NBINS - 1)) begin
                    dcnt_next  = '0;
                    state_next = (READ_LAT == 0) ? ST_HOLD : ST_DRAIN;
                end else begin
                    addr_next = addr + ADDR_W'(1);
                end
            end
            // Address stays on the last bin while the final reads return.
            ST_DRAIN: begin
                if (!bus.FftReady) begin
                    abort      = 1'b1;
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end else if (dcnt == 2'(READ_LAT - 1)) begin
                    state_next = ST_HOLD;
                end else begin
                    dcnt_next = dcnt + 2'd1;
                end
            end
            ST_HOLD: begin
`ifdef FFT_PEAK_AUTORUN_EN
                state_next = ST_START;
`else
                if (bus.Ack) state_next = ST_IDLE;
`endif
            end
            default: state_next = ST_IDLE;
        endcase
    end

    fft_peak_tracker #(
        .READ_LAT (READ_LAT)
    ) u_tracker (
        .clk       (Clk),
        .rst       (Reset),
        .req_valid (state == ST_SCAN),
        .req_first (addr == ADDR_W'(SKIP_DC)),
        .req_addr  (addr),
        .result    (bus.Result),
        .flush     (abort),
        .commit    (state == ST_HOLD),
        .peak_bin  (peak_bin),
        .peak_mag  (peak_mag)
    );

    assign bus.FftStart  = (state == ST_START);
    assign bus.Inspect   = ((state == ST_SCAN) || (state == ST_DRAIN)) ? addr : '0;
    assign bus.PeakBin   = peak_bin;
    assign bus.PeakMag   = peak_mag;
    assign bus.PeakValid = (state == ST_HOLD);
    assign bus.Busy      = (state != ST_IDLE);
    assign bus.Err       = err_q;

endmodule

// File: tb/tb_fft_peak_ctrl.sv
// Directed bench for fft_peak_ctrl: dut_a (SKIP_DC=1, READ_LAT=1) and dut_b (SKIP_DC=0, READ_LAT=2).
module tb_fft_peak_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic go_a = 1'b0;
    logic go_b = 1'b0;
    logic fft_done = 1'b0;
    logic fft_ready = 1'b0;
    logic ack = 1'b0;
    logic sel = 1'b0;

    int total = 0;
    int bad = 0;

    logic [15:0] mem [256];
    logic [7:0]  lat_a  = '0;
    logic [7:0]  lat_b1 = '0;
    logic [7:0]  lat_b2 = '0;

    fft_peak_ctrl_if ba();
    fft_peak_ctrl_if bb();

    fft_peak_ctrl #(.NBINS(16), .SKIP_DC(1), .READ_LAT(1), .TIMEOUT(32)) dut_a (
        .Clk(clk), .Reset(reset), .bus(ba.master)
    );

    fft_peak_ctrl #(.NBINS(16), .SKIP_DC(0), .READ_LAT(2), .TIMEOUT(32)) dut_b (
        .Clk(clk), .Reset(reset), .bus(bb.master)
    );

    always #5 clk = ~clk;

    // Spectrum memory with per-DUT read latency.
    always @(posedge clk) begin
        lat_a  <= ba.Inspect;
        lat_b1 <= bb.Inspect;
        lat_b2 <= lat_b1;
    end

    assign ba.Go       = go_a;
    assign bb.Go       = go_b;
    assign ba.FftDone  = fft_done;
    assign bb.FftDone  = fft_done;
    assign ba.FftReady = fft_ready;
    assign bb.FftReady = fft_ready;
    assign ba.Ack      = ack;
    assign bb.Ack      = ack;
    assign ba.Result   = mem[lat_a];
    assign bb.Result   = mem[lat_b2];

    wire [7:0]  o_inspect = sel ? bb.Inspect   : ba.Inspect;
    wire        o_valid   = sel ? bb.PeakValid : ba.PeakValid;
    wire [7:0]  o_bin     = sel ? bb.PeakBin   : ba.PeakBin;
    wire [15:0] o_mag     = sel ? bb.PeakMag   : ba.PeakMag;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 16; i++) mem[i] = 16'(i * 3);
        mem[9] = 16'h0400;
    endtask

    task automatic load_tie();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0010;
        mem[4]  = 16'h0200;
        mem[11] = 16'h0200;
    endtask

    task automatic run_measure(input logic which, output int first_addr, output int lat);
        sel = which;
        fft_ready = 1'b1;
        if (which) go_b = 1'b1; else go_a = 1'b1;
        tick();
        go_a = 1'b0;
        go_b = 1'b0;
        tick();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        first_addr = int'(o_inspect);
        lat = -1;
        for (int n = 0; n <= 60; n++) begin
            if (o_valid) begin
                lat = n;
                break;
            end
            tick();
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({ba.FftStart, ba.Inspect, ba.PeakBin, ba.PeakMag, ba.PeakValid, ba.Busy, ba.Err} !== 35'd0) begin
            bad++;
            $display("[TB] FAIL reset_a: got st=%b insp=%0d bin=%0d mag=%0d v=%b busy=%b err=%b, want all 0",
                     ba.FftStart, ba.Inspect, ba.PeakBin, ba.PeakMag, ba.PeakValid, ba.Busy, ba.Err);
        end
        total++;
        if ({bb.FftStart, bb.Inspect, bb.PeakBin, bb.PeakMag, bb.PeakValid, bb.Busy, bb.Err} !== 35'd0) begin
            bad++;
            $display("[TB] FAIL reset_b: got st=%b insp=%0d bin=%0d mag=%0d v=%b busy=%b err=%b, want all 0",
                     bb.FftStart, bb.Inspect, bb.PeakBin, bb.PeakMag, bb.PeakValid, bb.Busy, bb.Err);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat;
        load_ramp();
        sel = 1'b0;
        fft_ready = 1'b1;
        go_a = 1'b1;
        tick();
        go_a = 1'b0;
        total++;
        if (ba.FftStart !== 1'b1 || ba.Busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL basic_start: FftStart=%b Busy=%b, want 1 1", ba.FftStart, ba.Busy);
        end
        tick();
        total++;
        if (ba.FftStart !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_start_width: FftStart=%b, want 0", ba.FftStart);
        end
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            total++;
            if (ba.Inspect !== 8'(i)) begin
                bad++;
                $display("[TB] FAIL basic_addr: Inspect=%0d, want %0d", ba.Inspect, i);
            end
            tick();
        end
        total++;
        if (ba.Inspect !== 8'd15 || ba.PeakValid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_drain: Inspect=%0d PeakValid=%b, want 15 0", ba.Inspect, ba.PeakValid);
        end
        lat = -1;
        for (int n = 15; n <= 60; n++) begin
            if (ba.PeakValid) begin
                lat = n;
                break;
            end
            tick();
        end
        total++;
        if (lat != 16) begin
            bad++;
            $display("[TB] FAIL basic_valid_latency: got %0d cycles, want 16", lat);
        end
        total++;
        if (ba.PeakBin !== 8'd9 || ba.PeakMag !== 16'h0400) begin
            bad++;
            $display("[TB] FAIL basic_peak: bin=%0d mag=%h, want 9 0400", ba.PeakBin, ba.PeakMag);
        end
        tick();
        tick();
        tick();
        total++;
        if (ba.PeakValid !== 1'b1 || ba.Busy !== 1'b1 || ba.PeakBin !== 8'd9 || ba.PeakMag !== 16'h0400) begin
            bad++;
            $display("[TB] FAIL basic_hold: v=%b busy=%b bin=%0d mag=%h, want 1 1 9 0400",
                     ba.PeakValid, ba.Busy, ba.PeakBin, ba.PeakMag);
        end
        do_ack();
        total++;
        if (ba.PeakValid !== 1'b0 || ba.Busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_ack: v=%b busy=%b, want 0 0", ba.PeakValid, ba.Busy);
        end
    endtask

    task automatic test_abort();
        int guard;
        load_ramp();
        sel = 1'b0;
        fft_ready = 1'b1;
        go_a = 1'b1;
        tick();
        go_a = 1'b0;
        tick();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        guard = 0;
        while (ba.Inspect !== 8'd6 && guard < 20) begin
            tick();
            guard++;
        end
        total++;
        if (ba.Inspect !== 8'd6) begin
            bad++;
            $display("[TB] FAIL abort_reach: Inspect=%0d, want 6", ba.Inspect);
        end
        fft_ready = 1'b0;
        tick();
        total++;
        if (ba.Err !== 1'b1 || ba.Busy !== 1'b0 || ba.PeakValid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_err: err=%b busy=%b v=%b, want 1 0 0", ba.Err, ba.Busy, ba.PeakValid);
        end
        total++;
        if (ba.PeakBin !== 8'd9 || ba.PeakMag !== 16'h0400) begin
            bad++;
            $display("[TB] FAIL abort_restore: bin=%0d mag=%h, want 9 0400", ba.PeakBin, ba.PeakMag);
        end
        tick();
        total++;
        if (ba.Err !== 1'b0 || ba.PeakValid !== 1'b0 || ba.Inspect !== 8'd0) begin
            bad++;
            $display("[TB] FAIL abort_after: err=%b v=%b insp=%0d, want 0 0 0", ba.Err, ba.PeakValid, ba.Inspect);
        end
        fft_ready = 1'b1;
        tick();
    endtask

    task automatic test_tie();
        int first_addr;
        int lat;
        load_tie();
        run_measure(1'b0, first_addr, lat);
        total++;
        if (first_addr != 1 || lat != 16) begin
            bad++;
            $display("[TB] FAIL tie_timing: first=%0d lat=%0d, want 1 16", first_addr, lat);
        end
        total++;
        if (o_bin !== 8'd4 || o_mag !== 16'h0200) begin
            bad++;
            $display("[TB] FAIL tie_peak: bin=%0d mag=%h, want 4 0200", o_bin, o_mag);
        end
        do_ack();
    endtask

    task automatic test_dc();
        int first_addr;
        int lat;
        load_ramp();
        mem[0] = 16'hFFFF;
        run_measure(1'b1, first_addr, lat);
        total++;
        if (first_addr != 0 || lat != 18 || bb.Busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL dc_b_timing: first=%0d lat=%0d busy=%b, want 0 18 1", first_addr, lat, bb.Busy);
        end
        total++;
        if (o_bin !== 8'd0 || o_mag !== 16'hFFFF) begin
            bad++;
            $display("[TB] FAIL dc_b_peak: bin=%0d mag=%h, want 0 ffff", o_bin, o_mag);
        end
        do_ack();
        total++;
        if (bb.PeakValid !== 1'b0 || bb.Busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL dc_b_ack: v=%b busy=%b, want 0 0", bb.PeakValid, bb.Busy);
        end
        run_measure(1'b0, first_addr, lat);
        total++;
        if (first_addr != 1 || lat != 16) begin
            bad++;
            $display("[TB] FAIL dc_a_timing: first=%0d lat=%0d, want 1 16", first_addr, lat);
        end
        total++;
        if (o_bin !== 8'd9 || o_mag !== 16'h0400) begin
            bad++;
            $display("[TB] FAIL dc_a_peak: bin=%0d mag=%h, want 9 0400", o_bin, o_mag);
        end
        do_ack();
    endtask

    task automatic test_timeout();
        int lat;
        logic busy_prev;
        sel = 1'b0;
        fft_done = 1'b0;
        fft_ready = 1'b1;
        go_a = 1'b1;
        tick();
        go_a = 1'b0;
        tick();
        lat = -1;
        busy_prev = 1'b0;
        for (int n = 0; n <= 80; n++) begin
            if (ba.Err) begin
                lat = n;
                break;
            end
            busy_prev = ba.Busy;
            tick();
        end
        total++;
        if (lat != 32) begin
            bad++;
            $display("[TB] FAIL timeout_latency: Err after %0d wait cycles, want 32", lat);
        end
        total++;
        if (ba.Busy !== 1'b0 || busy_prev !== 1'b1) begin
            bad++;
            $display("[TB] FAIL timeout_busy: busy=%b prev=%b, want 0 1", ba.Busy, busy_prev);
        end
        tick();
        total++;
        if (ba.Err !== 1'b0 || ba.Busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL timeout_idle: err=%b busy=%b, want 0 0", ba.Err, ba.Busy);
        end
    endtask

    task automatic test_go_ack();
        int first_addr;
        int lat;
        int starts;
        load_ramp();
        run_measure(1'b0, first_addr, lat);
        total++;
        if (lat != 16 || ba.PeakValid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL goack_hold: lat=%0d v=%b, want 16 1", lat, ba.PeakValid);
        end
        go_a = 1'b1;
        ack = 1'b1;
        tick();
        go_a = 1'b0;
        ack = 1'b0;
        total++;
        if (ba.PeakValid !== 1'b0 || ba.Busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL goack_idle: v=%b busy=%b, want 0 0", ba.PeakValid, ba.Busy);
        end
        starts = 0;
        for (int n = 0; n < 6; n++) begin
            if (ba.FftStart || ba.Busy) starts++;
            tick();
        end
        total++;
        if (starts != 0) begin
            bad++;
            $display("[TB] FAIL goack_nostart: %0d busy/start cycles, want 0", starts);
        end
    endtask

    task automatic test_reset_mid_scan();
        load_ramp();
        sel = 1'b0;
        fft_ready = 1'b1;
        go_a = 1'b1;
        tick();
        go_a = 1'b0;
        tick();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        tick();
        tick();
        total++;
        if (ba.Inspect !== 8'd3 || ba.PeakMag === 16'h0000) begin
            bad++;
            $display("[TB] FAIL midscan_pre: Inspect=%0d mag=%h, want 3 nonzero", ba.Inspect, ba.PeakMag);
        end
        reset = 1'b1;
        tick();
        total++;
        if ({ba.FftStart, ba.Inspect, ba.PeakBin, ba.PeakMag, ba.PeakValid, ba.Busy, ba.Err} !== 35'd0) begin
            bad++;
            $display("[TB] FAIL midscan_reset: st=%b insp=%0d bin=%0d mag=%0d v=%b busy=%b err=%b, want all 0",
                     ba.FftStart, ba.Inspect, ba.PeakBin, ba.PeakMag, ba.PeakValid, ba.Busy, ba.Err);
        end
        reset = 1'b0;
        tick();
        total++;
        if (ba.Busy !== 1'b0 || ba.Inspect !== 8'd0 || ba.Err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midscan_after: busy=%b insp=%0d err=%b, want 0 0 0", ba.Busy, ba.Inspect, ba.Err);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        load_ramp();
        test_reset();
        test_basic();
        test_abort();
        test_tie();
        test_dc();
        test_timeout();
        test_go_ack();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_peak_ctrl.md
# fft_peak_ctrl

Sequencer that sits on top of `fft_sm` in the tuner datapath. It starts one FFT, waits for completion, and sweeps the `fft_sm` `Inspect` address through the spectrum bins. It tracks the largest `Result` magnitude and reports the peak bin index and magnitude to the pitch/display logic with a Valid/Ack handshake.

## Interface
One clock; reset is synchronous and active-high. Clock port `Clk`, reset port `Reset`.

Parameters:
- `NBINS`, 128: number of bins; addresses 0..NBINS-1; legal range 2..256.
- `SKIP_DC`, 1: 1 means the scan starts at bin 1, 0 means it starts at bin 0.
- `READ_LAT`, 1: cycles from `Inspect` driven to `Result` valid; legal range 0..3.
- `TIMEOUT`, 4096: maximum number of cycles spent in WAIT_FFT.

Ports:
- `Clk` in 1: clock.
- `Reset` in 1: synchronous active-high reset.
- `Go` in 1: request one measurement; sampled in IDLE only.
- `FftStart` out 1: one-cycle pulse to `fft_sm` `Start`.
- `FftDone` in 1: from `fft_sm` `Done`.
- `FftReady` in 1: from `fft_sm` `Ready`; results are readable while high.
- `Inspect` out 8: bin address to `fft_sm`.
- `Result` in 16: unsigned magnitude from `fft_sm`.
- `PeakBin` out 8: index of the peak bin.
- `PeakMag` out 16: magnitude of the peak bin.
- `PeakValid` out 1: peak result is available.
- `Ack` in 1: consumer has taken the peak result.
- `Busy` out 1: high in every state except IDLE.
- `Err` out 1: one-cycle pulse on timeout or on a lost `FftReady`.

## Operation
- States are IDLE, START, WAIT_FFT, SCAN, DRAIN, HOLD.
- IDLE → START when `Go`=1.
- START: `FftStart`=1 for exactly one cycle, then → WAIT_FFT. The timeout counter clears.
- WAIT_FFT: when `FftDone`=1 and `FftReady`=1, → SCAN with the address counter at SKIP_DC.
  - The counter reaching TIMEOUT-1 without done: `Err` pulses, → IDLE.
- SCAN: `Inspect` = counter, incrementing by 1 each cycle. After address NBINS-1 is driven, → DRAIN.
- DRAIN: lasts READ_LAT cycles, then → HOLD. With READ_LAT=0, DRAIN is skipped.
- A tag pipeline of depth READ_LAT carries each address alongside its request. `Result` is compared with the tag that matches it.
- Tracker rule:
  - The first scanned bin loads unconditionally.
  - A later bin replaces the stored peak only if `Result` > `PeakMag`, strictly unsigned. Ties therefore keep the lowest bin.
- HOLD: `PeakValid`=1 and `PeakBin`/`PeakMag` are stable. `Ack`=1 → IDLE.
- `FftReady`=0 during SCAN or DRAIN: abort, `Err` pulses, → IDLE.
  - `PeakValid` is not asserted.
  - `PeakBin`/`PeakMag` are restored to their values from before the measurement. A shadow register is updated only on HOLD entry.
- `Go` outside IDLE is ignored. `Ack` outside HOLD is ignored.
- `Go` and `Ack` together in HOLD: `Ack` is taken and `Go` is ignored; `Go` is sampled again in IDLE.
- `Inspect` is 0 in every state other than SCAN/DRAIN. In DRAIN it holds the last address.
- Reset at any point gives IDLE on the next edge.
- Reset values: `FftStart`=0, `Inspect`=0, `PeakBin`=0, `PeakMag`=0, `PeakValid`=0, `Busy`=0, `Err`=0, state IDLE.

## Timing
- `Go` sampled at edge k → `FftStart` high during cycle k+1.
- Done seen at edge d → first address on `Inspect` in cycle d+1.
- Scan length: S = NBINS − SKIP_DC cycles.
- `PeakValid` rises S + READ_LAT cycles after the first address.
- `Ack` sampled at edge a → `PeakValid` low and `Busy` low from cycle a+1.
- `Err` is high for exactly one cycle. In that cycle the state is already IDLE and `Busy`=0.

## Configuration
- `FFT_PEAK_AUTORUN_EN` defined:
  - IDLE enters START automatically and `Go` is ignored.
  - HOLD lasts one cycle, so `PeakValid` is a one-cycle pulse, then → START. `Ack` is ignored.
  - `PeakBin`/`PeakMag` keep their values until the next HOLD.
  - After `Err`, the block restarts from IDLE on the next cycle.
- Undefined: the Go/Ack handshake described above applies.

## Structure
- Package `fft_peak_pkg` holds:
  - the state enum;
  - `ADDR_W`=8 and `MAG_W`=16;
  - reset constants.
- Sub-module `fft_peak_tracker` contains the tag delay line, the compare/replace logic and the shadow restore. The top level holds the FSM, the address counter and the timeout counter.

## Test plan
- Basic, with NBINS=16, SKIP_DC=1, READ_LAT=1 and a model returning `Result`=bin*3 except bin 9=0x0400:
  - `Go` → `FftStart` 1 cycle, 15 addresses 1..15;
  - `PeakBin`=9, `PeakMag`=0x0400, `PeakValid` 16 cycles after the first address;
  - `Ack` → IDLE.
- Tie, with bins 4 and 11 both 0x0200 and all others 0x0010 → `PeakBin`=4.
- DC, with SKIP_DC=0 and bin 0=0xFFFF → `PeakBin`=0. With SKIP_DC=1 and the same data, bin 0 is not read.
- Abort, with `FftReady` dropped at address 6 → `Err` pulse, no `PeakValid`, previous peak 9/0x0400 retained.
- Timeout, with TIMEOUT=32 and `FftDone` never asserted → `Err` 32 cycles after START, then IDLE.
- Reset pulse mid-SCAN → all outputs at reset values next cycle. `Go`+`Ack` together in HOLD → IDLE with no new `FftStart`.
